// File: rtl/contador_frec_param.sv
// contador_frec_param
//   Frequency-select counter for the DPWM front end. Two raw push buttons
//   (increase / decrease) are synchronised, debounced and turned into
//   single-cycle step requests (plus optional hold-to-repeat). The requests
//   move a bounded, registered selection value that either saturates or
//   wraps at the configured limits.
//
// Ports
//   clk              system clock, all state on rising edge
//   reset            asynchronous active-high reset
//   boton_aumento    raw increase button (asynchronous to clk)
//   boton_disminuye  raw decrease button (asynchronous to clk)
//   enable           when low, step requests are discarded
//   numero_frec      current selection [MIN_VAL, MAX_VAL], registered
//   cambio           one-cycle pulse in the cycle after numero_frec changed
//   en_max           registered, high iff numero_frec == MAX_VAL
//   en_min           registered, high iff numero_frec == MIN_VAL

// One button channel: 2-FF synchroniser, debounce, press edge detect and
// optional auto-repeat. req_o is a single-cycle step request.
module contador_frec_param_canal #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned REPEAT_DELAY    = 0,
  parameter int unsigned REPEAT_PERIOD   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic boton_i,
  output logic req_o
);

  // Counter only needs to reach DEBOUNCE_CYCLES-1.
  localparam int unsigned DB_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic            sync1_q;
  logic            s_q;
  logic            stable_q, stable_d;
  logic            stable_prev_q;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;
  logic            press;
  logic            rep_fire;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q       <= 1'b0;
      s_q           <= 1'b0;
      db_cnt_q      <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
    end else begin
      sync1_q       <= boton_i;
      s_q           <= sync1_q;
      db_cnt_q      <= db_cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_q;
    end
  end

  // Counter runs only while the synchronised level disagrees with the
  // accepted level; any agreement restarts the qualification window.
  always_comb begin
    db_cnt_d = '0;
    stable_d = stable_q;
    if (s_q != stable_q) begin
      if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
        stable_d = s_q;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  assign press = stable_q & ~stable_prev_q;

  if (REPEAT_DELAY > 0) begin : g_rep
    localparam int unsigned RP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RP_W   = (RP_MAX > 1) ? $clog2(RP_MAX) : 1;

    typedef enum logic {REP_WAIT, REP_RUN} rep_state_t;

    rep_state_t      st_q, st_d;
    logic [RP_W-1:0] cnt_q, cnt_d;
    logic            fire;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        st_q  <= REP_WAIT;
        cnt_q <= '0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
      end
    end

    // cnt_q holds (cycles since press/last repeat) - 1, so a match on
    // N-1 fires exactly N cycles after the previous request.
    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q + 1'b1;
      fire  = 1'b0;
      if (!stable_q || press) begin
        st_d  = REP_WAIT;
        cnt_d = '0;
      end else if (st_q == REP_WAIT) begin
        if (cnt_q == RP_W'(REPEAT_DELAY - 1)) begin
          fire  = 1'b1;
          st_d  = REP_RUN;
          cnt_d = '0;
        end
      end else begin
        if (cnt_q == RP_W'(REPEAT_PERIOD - 1)) begin
          fire  = 1'b1;
          cnt_d = '0;
        end
      end
    end

    assign rep_fire = fire;
  end else begin : g_norep
    assign rep_fire = 1'b0;
  end

  assign req_o = press | rep_fire;

endmodule

module contador_frec_param #(
  parameter int unsigned WIDTH           = 3,
  parameter int unsigned MIN_VAL         = 0,
  parameter int unsigned MAX_VAL         = 7,
  parameter int unsigned RESET_VAL       = 0,
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned WRAP            = 0,
  parameter int unsigned REPEAT_DELAY    = 0,
  parameter int unsigned REPEAT_PERIOD   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             boton_aumento,
  input  logic             boton_disminuye,
  input  logic             enable,
  output logic [WIDTH-1:0] numero_frec,
  output logic             cambio,
  output logic             en_max,
  output logic             en_min
);

  localparam logic [WIDTH-1:0] MIN_W   = WIDTH'(MIN_VAL);
  localparam logic [WIDTH-1:0] MAX_W   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RESET_W = WIDTH'(RESET_VAL);

  logic             inc, dec;
  logic [WIDTH-1:0] val_q, val_d;
  logic             cambio_q, cambio_d;
  logic             en_max_q, en_max_d;
  logic             en_min_q, en_min_d;

  contador_frec_param_canal #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_canal_aumento (
    .clk     (clk),
    .reset   (reset),
    .boton_i (boton_aumento),
    .req_o   (inc)
  );

  contador_frec_param_canal #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_canal_disminuye (
    .clk     (clk),
    .reset   (reset),
    .boton_i (boton_disminuye),
    .req_o   (dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      val_q    <= RESET_W;
      cambio_q <= 1'b0;
      en_max_q <= (RESET_W == MAX_W);
      en_min_q <= (RESET_W == MIN_W);
    end else begin
      val_q    <= val_d;
      cambio_q <= cambio_d;
      en_max_q <= en_max_d;
      en_min_q <= en_min_d;
    end
  end

  // Simultaneous inc/dec cancel; requests while disabled are simply lost.
  always_comb begin
    val_d = val_q;
    if (enable && (inc ^ dec)) begin
      if (inc) begin
        if (val_q < MAX_W) begin
          val_d = val_q + 1'b1;
        end else if (WRAP != 0) begin
          val_d = MIN_W;
        end
      end else begin
        if (val_q > MIN_W) begin
          val_d = val_q - 1'b1;
        end else if (WRAP != 0) begin
          val_d = MAX_W;
        end
      end
    end
    cambio_d = (val_d != val_q);
    en_max_d = (val_d == MAX_W);
    en_min_d = (val_d == MIN_W);
  end

  assign numero_frec = val_q;
  assign cambio      = cambio_q;
  assign en_max      = en_max_q;
  assign en_min      = en_min_q;

endmodule
